// File: rtl/xm23_psw_pkg.sv
// rtl/xm23_psw_pkg.sv - PSW field layout, reserved-bit mask and helpers shared by the PSW unit
package xm23_psw_pkg;

  localparam int PSW_C   = 0;
  localparam int PSW_Z   = 1;
  localparam int PSW_N   = 2;
  localparam int PSW_SLP = 3;
  localparam int PSW_V   = 4;
  localparam int PSW_FLT = 8;

  localparam int CUR_PRI_LO  = 5;
  localparam int CUR_PRI_HI  = 7;
  localparam int PREV_PRI_LO = 13;
  localparam int PREV_PRI_HI = 15;

  localparam logic [15:0] PSW_RSVD_MASK = 16'h1E00;

  typedef struct packed {
    logic [2:0] prev_pri;
    logic [3:0] rsvd;
    logic       flt;
    logic [2:0] cur_pri;
    logic       v;
    logic       slp;
    logic       n;
    logic       z;
    logic       c;
  } psw_t;

  function automatic logic [15:0] psw_clean(input logic [15:0] v);
    return v & ~PSW_RSVD_MASK;
  endfunction

endpackage

// File: rtl/psw_lifo.sv
// rtl/psw_lifo.sv - saved-PSW stack for exception nesting; pointer saturates at 0 and DEPTH
module psw_lifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [15:0] data_i,
  output logic [15:0] top_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] top_idx;

  assign full_o  = (ptr_q == PW'(DEPTH));
  assign empty_o = (ptr_q == '0);
  assign top_idx = IW'(ptr_q - PW'(1));
  assign top_o   = mem_q[top_idx];

  always_comb begin
    ptr_d = ptr_q;
    if (push_i && !full_o)
      ptr_d = ptr_q + PW'(1);
    else if (pop_i && !empty_o)
      ptr_d = ptr_q - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  // Entries need no reset: a cleared pointer makes every stale slot unreachable.
  always_ff @(posedge clk) begin
    if (!rst && push_i && !full_o)
      mem_q[ptr_q[IW-1:0]] <= data_i;
  end

endmodule

// File: rtl/psw_unit.sv
// rtl/psw_unit.sv - architectural PSW with ALU merge, explicit write and exception LIFO; PSW_BYPASS_EN forwards next-PSW
module psw_unit
  import xm23_psw_pkg::*;
#(
  parameter int          STACK_DEPTH = 4,
  parameter logic [15:0] RESET_PSW   = 16'h00E0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [15:0] alu_psw,
  input  logic [15:0] alu_msk,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        exc_entry,
  input  logic [15:0] exc_psw,
  input  logic        exc_return,
  output logic [15:0] psw,
  output logic [15:0] psw_fwd,
  output logic        flag_c,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_v,
  output logic        stack_full,
  output logic        stack_empty,
  output logic [1:0]  stack_err
);

  logic [15:0] psw_q, psw_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        push, pop;
  logic [15:0] lifo_top;
  psw_t        entry_psw;

  psw_lifo #(.DEPTH(STACK_DEPTH)) u_lifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (psw_q),
    .top_o   (lifo_top),
    .full_o  (stack_full),
    .empty_o (stack_empty)
  );

  // Exception entry records the interrupted priority in PREV_PRI.
  always_comb begin
    entry_psw          = psw_t'(exc_psw);
    entry_psw.prev_pri = psw_q[CUR_PRI_HI:CUR_PRI_LO];
    entry_psw.rsvd     = '0;
  end

  always_comb begin
    psw_d = psw_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    pop   = 1'b0;
    if (exc_entry) begin
      psw_d = entry_psw;
      push  = !stack_full;
      if (stack_full)
        ovf_d = 1'b1;
    end else if (exc_return) begin
      if (stack_empty)
        unf_d = 1'b1;
      else begin
        pop   = 1'b1;
        psw_d = lifo_top;
      end
    end else if (wr_en) begin
      psw_d = psw_clean(wr_data);
    end else if (alu_valid) begin
      psw_d = psw_clean((psw_q & ~alu_msk) | (alu_psw & alu_msk));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psw_q <= psw_clean(RESET_PSW);
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      psw_q <= psw_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign psw       = psw_q;
  assign flag_c    = psw_q[PSW_C];
  assign flag_z    = psw_q[PSW_Z];
  assign flag_n    = psw_q[PSW_N];
  assign flag_v    = psw_q[PSW_V];
  assign stack_err = {unf_q, ovf_q};

`ifdef PSW_BYPASS_EN
  assign psw_fwd = psw_d;
`else
  assign psw_fwd = psw_q;
`endif

endmodule

// File: tb/tb_psw_unit.sv
// tb/tb_psw_unit.sv - directed plus randomized checks of psw_unit against a queue-based PSW model
module tb_psw_unit;

  localparam int          DEPTH = 4;
  localparam logic [15:0] RST_V = 16'h00E0;

  logic        clk = 1'b0;
  logic        rst, alu_valid, wr_en, exc_entry, exc_return;
  logic [15:0] alu_psw, alu_msk, wr_data, exc_psw;
  logic [15:0] psw, psw_fwd;
  logic        flag_c, flag_z, flag_n, flag_v, stack_full, stack_empty;
  logic [1:0]  stack_err;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_psw;
  logic [15:0] m_stack[$];
  logic [1:0]  m_err;

  always #5 clk = ~clk;

  psw_unit #(.STACK_DEPTH(DEPTH), .RESET_PSW(RST_V)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_psw(alu_psw), .alu_msk(alu_msk),
    .wr_en(wr_en), .wr_data(wr_data),
    .exc_entry(exc_entry), .exc_psw(exc_psw), .exc_return(exc_return),
    .psw(psw), .psw_fwd(psw_fwd),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_psw"}, psw, m_psw);
    chk({tag, "_flags"}, {12'd0, flag_v, flag_n, flag_z, flag_c},
        {12'd0, m_psw[4], m_psw[2], m_psw[1], m_psw[0]});
    chk({tag, "_full"}, {15'd0, stack_full}, {15'd0, m_stack.size() == DEPTH});
    chk({tag, "_empty"}, {15'd0, stack_empty}, {15'd0, m_stack.size() == 0});
    chk({tag, "_err"}, {14'd0, stack_err}, {14'd0, m_err});
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic r, input logic av, input logic [15:0] ap, input logic [15:0] am,
                      input logic we, input logic [15:0] wd,
                      input logic ee, input logic [15:0] ep, input logic er);
    logic [15:0] nxt;
    rst = r; alu_valid = av; alu_psw = ap; alu_msk = am;
    wr_en = we; wr_data = wd; exc_entry = ee; exc_psw = ep; exc_return = er;
    nxt = m_psw;
    if (r) begin
      nxt = RST_V;
      m_stack.delete();
      m_err = 2'b00;
    end else if (ee) begin
      if (m_stack.size() < DEPTH) m_stack.push_back(m_psw);
      else m_err[0] = 1'b1;
      nxt = {m_psw[7:5], 4'd0, ep[8:0]};
    end else if (er) begin
      if (m_stack.size() > 0) nxt = m_stack.pop_back();
      else m_err[1] = 1'b1;
    end else if (we) begin
      nxt = wd & 16'hE1FF;
    end else if (av) begin
      for (int b = 0; b < 16; b++)
        if (am[b]) nxt[b] = ap[b];
      nxt = nxt & 16'hE1FF;
    end
    #1;
    if (!r) begin
`ifdef PSW_BYPASS_EN
      chk("fwd_comb", psw_fwd, nxt);
`else
      chk("fwd_reg", psw_fwd, m_psw);
`endif
    end
    @(posedge clk);
    #1;
    m_psw = nxt;
    check_state("step");
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    m_psw = 16'hxxxx;
    m_err = 2'b00;
    @(negedge clk);
    step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("reset_psw", psw, 16'h00E0);
    chk("reset_empty", {15'd0, stack_empty}, 16'd1);
    chk("reset_err", {14'd0, stack_err}, 16'd0);

    step(1'b0, 1'b1, 16'h0013, 16'h0017, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("alu_merge", psw, 16'h00F3);

    step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'h1234, 1'b0, 16'h0, 1'b0);
    chk("wr_wins_rsvd", psw, 16'h0034);
    step(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("alu_msk0", psw, 16'h0034);

    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h00E5, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0040, 1'b0);
    chk("entry_psw", psw, 16'hE040);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    chk("return_psw", psw, 16'h00E5);

    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0020 * i + 16'h0001 * i, 1'b0);
    chk("ovf_err", {14'd0, stack_err}, 16'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    chk("pop_last", psw, 16'h00E5);

    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    chk("unf_err", {14'd0, stack_err}, 16'd3);
    idle();
    chk("err_sticky", {14'd0, stack_err}, 16'd3);
    step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("err_rst", {14'd0, stack_err}, 16'd0);

    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0115, 1'b1);
    chk("entry_over_ret", psw, 16'hE115);
    chk("entry_pushed", {15'd0, stack_empty}, 16'd0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 1) == 1, 16'($urandom), 16'($urandom),
           $urandom_range(0, 4) == 0, 16'($urandom),
           $urandom_range(0, 3) == 0, 16'($urandom),
           $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psw_unit.md
Name: psw_unit

Overview:
Status-register consumer for ALU flag results. ALU units (add/sub/logic) present a PSW value plus a per-bit mask; this block commits the masked merge into the architectural PSW. It also handles explicit PSW writes and exception entry/return, with a hardware LIFO of saved PSWs. It sits in the execute/writeback stage and feeds condition flags back to branch and conditional-execution logic.

Parameters:
STACK_DEPTH, 4, number of saved PSW entries in the exception LIFO (power of two, >=2)
RESET_PSW, 16'h00E0, PSW value after reset (current priority 7, all flags clear)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
alu_valid  in  1  commit an ALU flag result this cycle
alu_psw  in  16  PSW value produced by the ALU
alu_msk  in  16  bit mask: 1 = take bit from alu_psw
wr_en  in  1  explicit full PSW write
wr_data  in  16  explicit PSW write value
exc_entry  in  1  exception entry: push current PSW, load exc_psw
exc_psw  in  16  PSW to load on exception entry
exc_return  in  1  exception return: pop saved PSW into PSW
psw  out  16  architectural PSW (registered)
psw_fwd  out  16  forwarded PSW (see Optional Feature)
flag_c/flag_z/flag_n/flag_v  out  1 each  PSW bits 0/1/2/4
stack_full  out  1  LIFO holds STACK_DEPTH entries
stack_empty  out  1  LIFO holds 0 entries
stack_err  out  2  sticky {underflow, overflow}

Behaviour:
- PSW layout: C=0, Z=1, N=2, SLP=3, V=4, CUR_PRI=[7:5], FLT=8, reserved=[12:9], PREV_PRI=[15:13]. Reserved bits are forced to 0 on every write path.
- Reset (clk edge with rst=1): psw=RESET_PSW, LIFO pointer=0, stack_empty=1, stack_full=0, stack_err=2'b00. Reset mid-sequence discards all saved entries.
- All updates take effect on the clk edge. New value is visible on psw one cycle after the request; no backpressure; every request is accepted or dropped in its cycle.
- Priority per cycle, highest first: exc_entry > exc_return > wr_en > alu_valid. Only the winner acts. Lower requests in the same cycle are dropped silently.
- alu_valid: psw <= (psw & ~alu_msk) | (alu_psw & alu_msk). alu_msk=0 leaves psw unchanged.
- wr_en: psw <= wr_data.
- exc_entry, LIFO not full: push psw, then psw <= exc_psw with [15:13] replaced by the old psw[7:5].
- exc_entry, LIFO full: no push. psw is still loaded as above. stack_err[0] is set.
- exc_return, LIFO not empty: pop top entry into psw.
- exc_return, LIFO empty: psw unchanged. stack_err[1] is set.
- Pointer counts 0..STACK_DEPTH and never wraps. stack_full = (ptr==STACK_DEPTH). stack_empty = (ptr==0).
- stack_err bits are sticky and cleared only by rst.
- flag_* outputs are direct wires from psw.

Optional Feature:
- PSW_BYPASS_EN defined: psw_fwd is the combinational next-PSW value (result of the priority mux above) in the same cycle. This gives zero-cycle flag forwarding to a dependent branch.
- Not defined: psw_fwd = psw (registered), adding one cycle of flag latency. psw behaviour is identical in both builds.

Decomposition:
- Shared package xm23_psw_pkg holds:
  - bit-index localparams (PSW_C, PSW_Z, PSW_N, PSW_SLP, PSW_V, PSW_FLT)
  - CUR_PRI/PREV_PRI ranges
  - PSW_RSVD_MASK = 16'h1E00
  - a psw_t packed struct typedef
- Sub-module psw_lifo holds the storage array, the pointer, full/empty flags, and push/pop ports. The parent owns the priority mux and the error flags.

Test Plan:
1. Reset -> psw=16'h00E0, stack_empty=1, stack_err=0. Then alu_valid with alu_psw=16'h0013, alu_msk=16'h0017 -> psw=16'h00F3 next cycle (flag_c=1, flag_z=1, flag_v=1).
2. Same cycle wr_en (wr_data=16'h1234) and alu_valid (mask 16'hFFFF) -> psw=16'h0034: wr_en wins and reserved bits 12:9 are cleared. Repeat with alu_msk=0 alone -> psw unchanged.
3. psw=16'h00E5, exc_entry with exc_psw=16'h0040 -> psw=16'hE040 and stack depth 1. Then exc_return -> psw=16'h00E5, stack_empty=1.
4. Five exc_entry with STACK_DEPTH=4 -> stack_full after the 4th. The 5th loads psw but sets stack_err=2'b01. Then four pops restore the saved PSWs in reverse order.
5. exc_return on empty LIFO -> psw unchanged, stack_err[1]=1. It stays set until rst, and rst clears it.
6. exc_entry and exc_return in the same cycle -> only the push occurs. With PSW_BYPASS_EN defined, psw_fwd equals the new value in the request cycle; without it, psw_fwd lags psw_fwd by one cycle relative to the bypass build.
